// File: rtl/tff_mod_counter_pkg.sv
// Shared definitions for the modulo T flip-flop counter: direction encodings,
// legal parameter bounds and a ceiling-log2 helper for elaboration checks.
package tff_mod_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int WIDTH_MIN  = 2;
    localparam int WIDTH_MAX  = 16;
    localparam int MODULO_MIN = 2;

    // Number of bits needed to hold values 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/tff_mod_counter_if.sv
// Control and status bundle of the modulo counter. The master drives the
// controls and observes the count; the slave is the counter itself.
interface tff_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, load, d, clr_ovf,
        input  q, qn, tc, ovf
    );

    modport slave (
        input  en, up, load, d, clr_ovf,
        output q, qn, tc, ovf
    );
endinterface

// File: rtl/tff_mod_counter_cell.sv
// Single toggle flip-flop with synchronous active-high reset.
module tff_mod_counter_cell (
    input  logic clk,
    input  logic rst,
    input  logic t_i,
    output logic q_o,
    output logic qn_o
);
    logic q_q;

    // Toggle on T, clear on reset.
    always_ff @(posedge clk) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= q_q ^ t_i;
    end

    assign q_o  = q_q;
    assign qn_o = ~q_q;
endmodule

// File: rtl/tff_mod_counter.sv
// Modulo up/down counter built from a chain of T flip-flop cells. The next
// count (load, count, wrap or saturate) is computed here and applied to the
// cells as toggles, so a load is also realised through the T inputs.
module tff_mod_counter
    import tff_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 10,
    parameter int SATURATE = 0
) (
    input logic               clk,
    input logic               rst,
    tff_mod_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULO - 1);

    // Reject illegal widths/moduli at elaboration.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || MODULO < MODULO_MIN ||
        MODULO > (1 << WIDTH) || clog2(MODULO) > WIDTH) begin : g_bad_param
        $error("tff_mod_counter: illegal WIDTH=%0d / MODULO=%0d", WIDTH, MODULO);
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_qn;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_q,  tc_d;
    logic             ovf_q, ovf_d;
    logic             at_bnd;
    logic             load_big;

    assign at_bnd   = (bus.up == DIR_UP) ? (cnt_q == QMAX) : (cnt_q == '0);
    assign load_big = (bus.d > QMAX);

    // Next count and next status flags; priority LOAD > EN > hold.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = bus.clr_ovf ? 1'b0 : ovf_q;
        if (bus.load) begin
            cnt_d = load_big ? QMAX : bus.d;
            if (load_big) ovf_d = 1'b1;
        end else if (bus.en) begin
            if (at_bnd) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                if (SATURATE == 0)
                    cnt_d = (bus.up == DIR_UP) ? '0 : QMAX;
            end else if (bus.up == DIR_UP) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // One T cell per bit, toggled wherever the next count differs.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_mod_counter_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .t_i  (cnt_d[i] ^ cnt_q[i]),
            .q_o  (cnt_q[i]),
            .qn_o (cnt_qn[i])
        );
    end

    // Registered terminal-count pulse and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q   = cnt_q;
    assign bus.qn  = cnt_qn;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for tff_mod_counter: a wrapping and a saturating instance,
// WIDTH=4, MODULO=10, with hand-computed expectations.
module tb_tff_mod_counter;
    import tff_mod_counter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tff_mod_counter_if #(.WIDTH(4)) bw ();
    tff_mod_counter_if #(.WIDTH(4)) bs ();

    tff_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bw)
    );

    tff_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input int q, input int tc, input int ovf);
        chk({tag, " q"},   int'(bw.q),   q);
        chk({tag, " qn"},  int'(bw.qn),  (~q) & 15);
        chk({tag, " tc"},  int'(bw.tc),  tc);
        chk({tag, " ovf"}, int'(bw.ovf), ovf);
    endtask

    task automatic chk_s(input string tag, input int q, input int tc, input int ovf);
        chk({tag, " q"},   int'(bs.q),   q);
        chk({tag, " tc"},  int'(bs.tc),  tc);
        chk({tag, " ovf"}, int'(bs.ovf), ovf);
    endtask

    task automatic drv_w(input logic en, input logic up, input logic load,
                         input logic [3:0] d, input logic clr);
        bw.en = en; bw.up = up; bw.load = load; bw.d = d; bw.clr_ovf = clr;
    endtask

    task automatic drv_s(input logic en, input logic up, input logic load,
                         input logic [3:0] d, input logic clr);
        bs.en = en; bs.up = up; bs.load = load; bs.d = d; bs.clr_ovf = clr;
    endtask

    initial begin
        // Reset with load and enable asserted: reset wins.
        rst = 1'b1;
        drv_w(1'b1, DIR_UP, 1'b1, 4'd7, 1'b0);
        drv_s(1'b1, DIR_UP, 1'b1, 4'd7, 1'b0);
        step(); step();
        chk_w("reset", 0, 0, 0);
        chk_s("sat reset", 0, 0, 0);

        // Count up through the wrap.
        rst = 1'b0;
        drv_s(1'b0, DIR_UP, 1'b0, 4'd0, 1'b0);
        drv_w(1'b1, DIR_UP, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_w($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0, (i == 10) ? 1 : 0);
        end

        // Immediate direction change: down from 0 wraps to 9, then 8.
        drv_w(1'b1, DIR_DN, 1'b0, 4'd0, 1'b0);
        step(); chk_w("dn wrap", 9, 1, 1);
        step(); chk_w("dn 8", 8, 0, 1);

        // Clear OVF while holding.
        drv_w(1'b0, DIR_DN, 1'b0, 4'd0, 1'b1);
        step(); chk_w("clr hold", 8, 0, 0);

        // Oversized load clamps and sets OVF.
        drv_w(1'b0, DIR_UP, 1'b1, 4'd12, 1'b0);
        step(); chk_w("load 12", 9, 0, 1);

        // Load beats enable.
        drv_w(1'b1, DIR_UP, 1'b1, 4'd5, 1'b0);
        step(); chk_w("load 5", 5, 0, 1);

        // Count 5 -> 9.
        drv_w(1'b1, DIR_UP, 1'b0, 4'd0, 1'b0);
        for (int i = 6; i <= 9; i++) begin
            step();
            chk_w($sformatf("up%0d", i), i, 0, 1);
        end

        // Wrap together with CLR_OVF: set wins.
        drv_w(1'b1, DIR_UP, 1'b0, 4'd0, 1'b1);
        step(); chk_w("set vs clr", 0, 1, 1);

        // CLR_OVF alone.
        drv_w(1'b0, DIR_UP, 1'b0, 4'd0, 1'b1);
        step(); chk_w("clr only", 0, 0, 0);

        // Legal load of 6, then reset mid-load discards the load.
        drv_w(1'b0, DIR_UP, 1'b1, 4'd6, 1'b0);
        step(); chk_w("load 6", 6, 0, 0);
        drv_w(1'b1, DIR_UP, 1'b1, 4'd3, 1'b0);
        rst = 1'b1;
        step(); chk_w("rst mid", 0, 0, 0);
        rst = 1'b0;
        drv_w(1'b0, DIR_UP, 1'b0, 4'd0, 1'b0);

        // Saturating instance: load 9, push up for 3 edges.
        drv_s(1'b0, DIR_UP, 1'b1, 4'd9, 1'b0);
        step(); chk_s("sat load9", 9, 0, 0);
        drv_s(1'b1, DIR_UP, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_s($sformatf("sat hold%0d", i), 9, 1, 1);
        end
        drv_s(1'b1, DIR_DN, 1'b0, 4'd0, 1'b0);
        step(); chk_s("sat dn", 8, 0, 1);

        // Saturate at the low boundary.
        drv_s(1'b0, DIR_DN, 1'b1, 4'd0, 1'b1);
        step(); chk_s("sat load0", 0, 0, 0);
        drv_s(1'b1, DIR_DN, 1'b0, 4'd0, 1'b0);
        step(); chk_s("sat low", 0, 1, 1);
        drv_s(1'b0, DIR_DN, 1'b0, 4'd0, 1'b0);
        step(); chk_s("sat idle", 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
